// File: rtl/rd_reconstruct.sv
// Rebuilds dividend = quotient*divisor + remainder with a W-cycle shift-add multiply.
// Optional consistency flag on err when RD_RECON_CHECK_EN is defined.
module rd_reconstruct #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     quotient,
    input  logic [W-1:0]     divisor,
    input  logic [W-1:0]     remainder,
    output logic [2*W-1:0]   dividend,
    output logic             busy,
    output logic             done
`ifdef RD_RECON_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [W-1:0]      mq_r;
    logic [2*W-1:0]    md_r;
    logic [2*W-1:0]    acc_r;
    logic [CW-1:0]     cnt_r;
    logic [2*W-1:0]    dividend_r;
    logic              busy_r;
    logic              done_r;
    logic [2*W-1:0]    acc_next_s;

`ifdef RD_RECON_CHECK_EN
    logic              inv_r;
    logic              err_r;

    // A remainder is only legal when the divisor is non-zero and the remainder is below it.
    function automatic logic operands_invalid(input logic [W-1:0] y, input logic [W-1:0] r);
        return (y == {W{1'b0}}) || (r >= y);
    endfunction
`endif

    // Partial-product accumulate for the current multiplier bit.
    always_comb begin
        acc_next_s = acc_r;
        if (mq_r[0]) begin
            acc_next_s = acc_r + md_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            mq_r       <= {W{1'b0}};
            md_r       <= {(2*W){1'b0}};
            acc_r      <= {(2*W){1'b0}};
            cnt_r      <= {CW{1'b0}};
            dividend_r <= {(2*W){1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef RD_RECON_CHECK_EN
            inv_r      <= 1'b0;
            err_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mq_r    <= quotient;
                        md_r    <= {{W{1'b0}}, divisor};
                        acc_r   <= {{W{1'b0}}, remainder};
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
`ifdef RD_RECON_CHECK_EN
                        inv_r   <= operands_invalid(divisor, remainder);
`endif
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    acc_r <= acc_next_s;
                    md_r  <= md_r << 1;
                    mq_r  <= mq_r >> 1;
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    // The last step's add is folded straight into the published result.
                    if (cnt_r == CW'(W-1)) begin
                        dividend_r <= acc_next_s;
                        done_r     <= 1'b1;
                        state_r    <= DONE;
`ifdef RD_RECON_CHECK_EN
                        err_r      <= inv_r;
`endif
                    end else begin
                        state_r    <= RUN;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign dividend = dividend_r;
    assign busy     = busy_r;
    assign done     = done_r;
`ifdef RD_RECON_CHECK_EN
    assign err      = err_r;
`endif

endmodule
